instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the control unit and register file. Holds the PC and issues

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/instr_fetch_unit_if.sv | 62 ++++++
 rtl/pc_register.sv | 24 ++
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field layout and the
// fetch-stage state encoding.
package cpu_pkg;

  localparam int CPU_PC_W    = 8;
  localparam int CPU_INSTR_W = 16;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BEQ = 4'h8;
  localparam logic [3:0] OP_BNE = 4'h9;

  // Low bit of each field; imm6 overlaps rs2 and the low three bits.
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decoded-field output
// handshake, and execute-stage redirect. master = fetch unit side.
interface instr_fetch_unit_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = CPU_PC_W,
  parameter int INSTR_W = CPU_INSTR_W
);

  logic               fetch_en;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic               instr_accept;
  logic [3:0]         opcode;
  logic [2:0]         rd;
  logic [2:0]         rs1;
  logic [2:0]         rs2;
  logic [5:0]         imm;
  logic [PC_W-1:0]    pc_out;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;

  modport master (
    input  fetch_en,
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata,
    output instr_valid,
    input  instr_accept,
    output opcode,
    output rd,
    output rs1,
    output rs2,
    output imm,
    output pc_out,
    input  branch_taken,
    input  branch_target
  );

  modport slave (
    output fetch_en,
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata,
    input  instr_valid,
    output instr_accept,
    input  opcode,
    input  rd,
    input  rs1,
    input  rs2,
    input  imm,
    input  pc_out,
    output branch_taken,
    output branch_target
  );

endinterface

// File: rtl/pc_register.sv
// Program counter with a redirect load and a +1 step; load wins over step and
// the step wraps silently at 2^W.
module pc_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         inc,
  output logic [W-1:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one instruction-memory request at a time, captures the
// returned word into IR and hands its fields downstream; redirects kill work.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = CPU_PC_W,
  parameter int INSTR_W = CPU_INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  instr_fetch_unit_if.master bus
);

  fetch_state_t       state_reg;
  fetch_state_t       state_next;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    drain_addr_reg;
  logic [PC_W-1:0]    pc_out_reg;
  logic [INSTR_W-1:0] ir_reg;
  logic               capture;
  logic               start_drain;

  // A word is kept only if the request completes without a redirect alongside it.
  assign capture     = (state_reg == REQ) && bus.imem_ready && !bus.branch_taken;
  assign start_drain = (state_reg == REQ) && !bus.imem_ready && bus.branch_taken;

  pc_register #(
    .W (PC_W)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .load       (bus.branch_taken),
    .load_value (bus.branch_target),
    .inc        (capture),
    .pc         (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.fetch_en) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ready) begin
          state_next = bus.branch_taken ? REQ : HOLD;
        end else if (bus.branch_taken) begin
          state_next = DRAIN;
        end
      end
      HOLD: begin
        if (bus.branch_taken) begin
          state_next = REQ;
        end else if (bus.instr_accept) begin
          state_next = bus.fetch_en ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (bus.imem_ready) begin
          state_next = bus.fetch_en ? REQ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_reg         <= '0;
      pc_out_reg     <= '0;
      drain_addr_reg <= '0;
    end else begin
      if (capture) begin
        ir_reg     <= bus.imem_rdata;
        pc_out_reg <= pc;
      end
      // The PC moves to the target at once, so remember the address still on the bus.
      if (start_drain) begin
        drain_addr_reg <= pc;
      end
    end
  end

  assign bus.imem_req    = (state_reg == REQ) || (state_reg == DRAIN);
  assign bus.imem_addr   = (state_reg == DRAIN) ? drain_addr_reg : pc;
  assign bus.instr_valid = (state_reg == HOLD);
  assign bus.opcode      = ir_reg[OPC_LSB +: 4];
  assign bus.rd          = ir_reg[RD_LSB  +: 3];
  assign bus.rs1         = ir_reg[RS1_LSB +: 3];
  assign bus.rs2         = ir_reg[RS2_LSB +: 3];
  assign bus.imm         = ir_reg[IMM_LSB +: 6];
  assign bus.pc_out      = pc_out_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: one outstanding request at most, one held word at most.
  logic [15:0] mem [256];
  logic [7:0]  m_pc;
  logic        m_busy;
  logic        m_killed;
  logic [7:0]  m_req_addr;
  logic        m_valid;
  logic [15:0] m_ir;
  logic [7:0]  m_pcout;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, act, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_busy = 1'b0; m_killed = 1'b0; m_req_addr = 8'h00;
    m_valid = 1'b0; m_ir = 16'h0000; m_pcout = 8'h00;
  endtask

  // Called at a falling edge: compare outputs, drive inputs, advance model one cycle.
  task automatic step(input logic fe, input logic rdy, input logic acc,
                      input logic br, input logic [7:0] tgt);
    logic pre_busy, pre_valid, pre_killed, done, take;
    check("imem_req", bus.imem_req, m_busy);
    if (m_busy) check("imem_addr", bus.imem_addr, m_req_addr);
    check("instr_valid", bus.instr_valid, m_valid);
    if (m_valid) begin
      check("opcode", bus.opcode, m_ir[15:12]);
      check("rd",     bus.rd,     m_ir[11:9]);
      check("rs1",    bus.rs1,    m_ir[8:6]);
      check("rs2",    bus.rs2,    m_ir[5:3]);
      check("imm",    bus.imm,    m_ir[5:0]);
      check("pc_out", bus.pc_out, m_pcout);
    end
    bus.fetch_en      = fe;
    bus.imem_ready    = rdy;
    bus.imem_rdata    = m_busy ? mem[m_req_addr] : 16'($urandom);
    bus.instr_accept  = acc;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    if (acc && m_valid && !br)
      $display("ACC pc=%02h instr=%04h", m_pcout, m_ir);

    pre_busy   = m_busy;
    pre_valid  = m_valid;
    pre_killed = m_killed;
    done = pre_busy && rdy;
    take = done && !pre_killed && !br;
    if (take) begin
      m_ir = mem[m_req_addr]; m_pcout = m_req_addr; m_valid = 1'b1; m_pc = m_pc + 8'd1;
    end
    if (done) m_busy = 1'b0;
    if (br) begin
      m_pc = tgt; m_valid = 1'b0;
      if (m_busy) m_killed = 1'b1;
    end else if (acc && pre_valid) begin
      m_valid = 1'b0;
    end
    if (!m_busy && !m_valid &&
        (fe || (br && (pre_valid || (pre_busy && !pre_killed))))) begin
      m_busy = 1'b1; m_req_addr = m_pc; m_killed = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    bus.fetch_en = 0; bus.imem_ready = 0; bus.imem_rdata = '0;
    bus.instr_accept = 0; bus.branch_taken = 0; bus.branch_target = '0;
    reset = 1'b1;
    #1;
    check("rst_imem_req", bus.imem_req, 1'b0);
    check("rst_instr_valid", bus.instr_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    check("rst_pc_out", bus.pc_out, 8'h00);
    check("rst_opcode", bus.opcode, 4'h0);
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] vpat;
    logic [3:0] got_op [4];
    logic [7:0] got_pc [4];
    logic [3:0] exp_op [3];
    int nfound, stable;

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h5789;
    exp_op[0] = 4'h0; exp_op[1] = 4'h1; exp_op[2] = 4'h5;
    @(negedge clk);

    // 1: zero-wait memory, always accept
    reset_dut();
    vpat = '0; nfound = 0;
    for (int c = 0; c < 7; c++) begin
      vpat[c] = bus.instr_valid;
      if (bus.instr_valid && nfound < 4) begin
        got_op[nfound] = bus.opcode; got_pc[nfound] = bus.pc_out; nfound++;
      end
      step(1, 1, 1, 0, 8'h00);
    end
    check("t1_valid_pattern", vpat, 7'b1010100);
    check("t1_count", nfound, 3);
    for (int k = 0; k < 3; k++) begin
      check("t1_opcode", got_op[k], exp_op[k]);
      check("t1_pc_out", got_pc[k], k);
    end

    // 2: ready delayed three cycles; 3: held five cycles without accept
    reset_dut();
    step(1, 0, 0, 0, 8'h00);
    stable = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.imem_req && bus.imem_addr == 8'h00) stable++;
      step(1, (c == 3), 0, 0, 8'h00);
    end
    check("t2_req_cycles", stable, 4);
    check("t2_captured", bus.instr_valid, 1'b1);
    for (int c = 0; c < 5; c++) begin
      check("t3_opcode", bus.opcode, 4'h0);
      check("t3_pc_out", bus.pc_out, 8'h00);
      check("t3_no_req", bus.imem_req, 1'b0);
      step(1, 1, 0, 0, 8'h00);
    end
    step(1, 0, 1, 0, 8'h00);
    check("t3_next_addr", bus.imem_addr, 8'h01);

    // 4: redirect while a request to 0x05 is pending
    reset_dut();
    step(1, 0, 0, 1, 8'h05);
    step(1, 0, 0, 0, 8'h00);
    check("t4_addr05", bus.imem_addr, 8'h05);
    step(1, 0, 0, 1, 8'h40);
    check("t4_drain_addr", bus.imem_addr, 8'h05);
    step(1, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 8'h00);
    check("t4_dropped", bus.instr_valid, 1'b0);
    check("t4_new_addr", bus.imem_addr, 8'h40);
    step(1, 1, 0, 0, 8'h00);
    check("t4_pc_out", bus.pc_out, 8'h40);
    step(1, 0, 1, 0, 8'h00);

    // 5: PC wrap
    reset_dut();
    step(1, 0, 0, 1, 8'hFF);
    check("t5_addr_ff", bus.imem_addr, 8'hFF);
    step(1, 1, 0, 0, 8'h00);
    check("t5_pc_out_ff", bus.pc_out, 8'hFF);
    step(1, 0, 1, 0, 8'h00);
    check("t5_wrap_req", bus.imem_req, 1'b1);
    check("t5_wrap_addr", bus.imem_addr, 8'h00);
    step(1, 1, 1, 0, 8'h00);

    // 6: reset while holding a valid instruction
    reset_dut();
    step(1, 0, 0, 1, 8'h33);
    step(1, 1, 0, 0, 8'h00);
    check("t6_pre_valid", bus.instr_valid, 1'b1);
    reset_dut();
    step(1, 0, 0, 0, 8'h00);
    check("t6_restart_addr", bus.imem_addr, 8'h00);
    check("t6_restart_req", bus.imem_req, 1'b1);

    // Randomized traffic
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      logic fe, rdy, acc, br;
      fe  = ($urandom_range(0, 7) != 0);
      rdy = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      acc = ($urandom_range(0, 2) != 0);
      br  = fe && ($urandom_range(0, 11) == 0);
      step(fe, rdy, acc, br, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
